dma_priority_arb: RTL
=====================

Name: dma_priority_arb

Overview:
- Channel request/priority arbiter for the 8237A-style DMA controller.
- Sits directly upstream of the timing/control FSM inside dma_top.
- Samples DREQ lines and software requests, and resolves priority (fixed or rotating).
- Runs the HRQ/HLDA bus-hold handshake, then drives DACK and a granted-channel id to the timing/control stage until that stage reports end of service.

Parameters:
- NUM_CH, 4: number of DMA channels. Channel 0 is highest priority in fixed mode.
- CH_W, 2: width of the channel id, equal to clog2(NUM_CH).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- DREQ  input  NUM_CH  raw peripheral requests, polarity set by dreq_sense_low.
- sw_req  input  NUM_CH  software request register bits, always active-high, not masked.
- mask  input  NUM_CH  1 = hardware DREQ of that channel ignored.
- ctrl_disable  input  1  command reg bit 2; 1 = no new grants.
- rotate_en  input  1  command reg bit 4; 1 = rotating priority.
- dreq_sense_low  input  1  command reg bit 6; 1 = DREQ active-low.
- dack_sense_high  input  1  command reg bit 7; 1 = DACK active-high.
- HLDA  input  1  hold acknowledge from CPU.
- svc_done  input  1  one-cycle pulse from timing/control: service of granted channel complete (TC/EOP/single transfer end).
- HRQ  output  1  hold request to CPU.
- DACK  output  NUM_CH  channel acknowledges, polarity per dack_sense_high.
- grant_valid  output  1  1 while in SERVE.
- grant_ch  output  CH_W  granted channel id, valid when grant_valid = 1.
- req_pending  output  NUM_CH  registered effective request vector, for status register bits 7:4.

Behaviour:
- Stage 1 register: eff_req <= ((DREQ ^ {NUM_CH{dreq_sense_low}}) & ~mask) | sw_req. req_pending = eff_req.
- Priority pointer ptr (CH_W bits) names the highest-priority channel. Fixed mode: ptr = 0. Rotating mode: after a service, ptr = served channel + 1 modulo NUM_CH. Wrap 3 -> 0 for NUM_CH = 4.
- Winner: first set bit of eff_req scanning ptr, ptr+1, ... modulo NUM_CH.
- FSM states: IDLE, REQ, SERVE.
- IDLE:
  - If ctrl_disable = 0 and |eff_req, latch winner into ch_q, set HRQ = 1, go to REQ.
  - Latency: request present before edge k is in eff_req after edge k; HRQ = 1 after edge k+1.
- REQ:
  - HRQ = 1.
  - If eff_req[ch_q] drops before HLDA, drop HRQ and return to IDLE (cancel, no DACK).
  - If HLDA = 1, go to SERVE. DACK[ch_q] asserts and grant_valid = 1 on that same edge.
  - Winner is frozen: a higher-priority request arriving in REQ does not preempt.
  - ctrl_disable rising in REQ has no effect; only new grants are blocked.
- SERVE:
  - HRQ = 1, grant_ch = ch_q, exactly one DACK active.
  - On svc_done: deassert HRQ, DACK and grant_valid on the next edge, update ptr if rotate_en, go to IDLE.
  - If HLDA falls without svc_done: abort to IDLE, deassert all outputs, ptr unchanged.
  - svc_done and HLDA fall in the same cycle: treated as svc_done (ptr updates).
- Back-to-back: IDLE always spends at least one cycle with HRQ = 0 between grants.
- svc_done in IDLE or REQ is ignored.
- Reset values: state = IDLE, HRQ = 0, grant_valid = 0, grant_ch = 0, eff_req = 0, ptr = 0, DACK = inactive level. Inactive DACK = all 1s if dack_sense_high = 0, else all 0s (DACK polarity applied combinationally).
- RESET mid-service forces reset values on the next edge regardless of HLDA.

Optional Feature:
- Macro DMA_ROTATE_PRIORITY_EN.
- Defined: rotating priority as specified.
- Undefined: ptr tied to 0, rotate_en input ignored, fixed priority only. Removes the pointer register and rotate logic.

Test Plan:
- Fixed priority, DREQ = 4'b1010, mask = 0, rotate_en = 0, HLDA returned 2 cycles after HRQ -> HRQ 2 edges after DREQ, grant_ch = 1, DACK = 4'b1101 (active-low default). After svc_done, a second grant to ch 1 again, never ch 3 while ch 1 requests.
- Rotating, all DREQ held high, 4 services -> grant order 0,1,2,3, then wrap to 0. ptr reads 1,2,3,0 after each svc_done.
- mask = 4'b0001, DREQ = 4'b0001, sw_req = 0 -> HRQ stays 0. Then sw_req = 4'b0001 -> grant_ch = 0 despite the mask.
- dreq_sense_low = 1, dack_sense_high = 1, DREQ = 4'b1011 -> grant ch 2, DACK = 4'b0100.
- Request drop: DREQ[2] pulsed in IDLE, removed before HLDA -> HRQ returns to 0, no DACK ever asserted. HLDA dropped in SERVE -> outputs clear next edge, ptr unchanged.
- RESET asserted in SERVE with HLDA = 1 -> next edge HRQ = 0, DACK inactive, state IDLE. ctrl_disable = 1 with DREQ = 4'b1111 -> no HRQ.

Source files
------------

// File: rtl/dma_priority_arb_if.sv
// Request/grant bundle between the DMA priority arbiter and its surroundings.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever drives the requests and the CPU hold handshake.
interface dma_priority_arb_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0] DREQ;
    logic [NUM_CH-1:0] sw_req;
    logic [NUM_CH-1:0] mask;
    logic              ctrl_disable;
    logic              rotate_en;
    logic              dreq_sense_low;
    logic              dack_sense_high;
    logic              HLDA;
    logic              svc_done;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_ch;
    logic [NUM_CH-1:0] req_pending;

    modport slave (
        input  DREQ, sw_req, mask, ctrl_disable, rotate_en,
               dreq_sense_low, dack_sense_high, HLDA, svc_done,
        output HRQ, DACK, grant_valid, grant_ch, req_pending
    );

    modport master (
        output DREQ, sw_req, mask, ctrl_disable, rotate_en,
               dreq_sense_low, dack_sense_high, HLDA, svc_done,
        input  HRQ, DACK, grant_valid, grant_ch, req_pending
    );
endinterface

// File: rtl/dma_priority_arb.sv
// DMA channel request/priority arbiter (8237A style).
// - Registers the effective request vector, which is hardware DREQ after the
//   polarity and mask are applied, OR'd with the software requests.
// - Picks a winner, runs the HRQ/HLDA hold handshake, and holds DACK and
//   grant_ch until the timing/control stage pulses svc_done.
// Optional feature: define DMA_ROTATE_PRIORITY_EN to build rotating priority.
// When it is undefined, the priority pointer is constant 0 and rotate_en is
// ignored, so the arbiter uses fixed priority with channel 0 highest.
module dma_priority_arb #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input logic               CLK,
    input logic               RESET,
    dma_priority_arb_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;

    state_t            state_reg, state_next;
    logic [NUM_CH-1:0] eff_req_reg, eff_req_next;
    logic [CH_W-1:0]   ch_q_reg, ch_q_next;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   winner;
    logic [NUM_CH-1:0] dack_act;

    // Effective request: DREQ is normalised to active-high, masked, then merged with sw_req.
    always_comb begin
        eff_req_next = ((bus.DREQ ^ {NUM_CH{bus.dreq_sense_low}}) & ~bus.mask) | bus.sw_req;
    end

`ifdef DMA_ROTATE_PRIORITY_EN
    logic [CH_W-1:0] ptr_reg, ptr_next;
    logic            svc_commit;

    assign svc_commit = (state_reg == SERVE) && bus.svc_done;

    // After a completed service the channel following the served one becomes highest priority.
    always_comb begin
        ptr_next = ptr_reg;
        if (svc_commit && bus.rotate_en) begin
            ptr_next = (ch_q_reg == CH_W'(NUM_CH - 1)) ? '0 : ch_q_reg + 1'b1;
        end
    end

    // Priority pointer register. An abort (HLDA lost) leaves it untouched.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;
`else
    logic unused_rotate_en;

    assign unused_rotate_en = bus.rotate_en;
    assign ptr              = '0;
`endif

    // Winner: the first set request scanning ptr, ptr+1, ... (mod NUM_CH).
    // The scan runs in reverse order so the closest channel to ptr is assigned last and wins.
    always_comb begin
        winner = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eff_req_reg[CH_W'((int'(ptr) + i) % NUM_CH)]) begin
                winner = CH_W'((int'(ptr) + i) % NUM_CH);
            end
        end
    end

    // Next state. In REQ the winner stays frozen. A dropped request cancels
    // before HLDA is considered, so DACK never goes to a channel that is no
    // longer asking. svc_done takes precedence over losing HLDA.
    always_comb begin
        state_next = state_reg;
        ch_q_next  = ch_q_reg;
        case (state_reg)
            IDLE: begin
                if (!bus.ctrl_disable && (|eff_req_reg)) begin
                    ch_q_next  = winner;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!eff_req_reg[ch_q_reg]) begin
                    state_next = IDLE;
                end else if (bus.HLDA) begin
                    state_next = SERVE;
                end
            end
            SERVE: begin
                if (bus.svc_done) begin
                    state_next = IDLE;
                end else if (!bus.HLDA) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latched channel and request pipeline registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= IDLE;
            ch_q_reg    <= '0;
            eff_req_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ch_q_reg    <= ch_q_next;
            eff_req_reg <= eff_req_next;
        end
    end

    // One-hot active DACK for the granted channel while serving.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_dack
            assign dack_act[gi] = (state_reg == SERVE) && (ch_q_reg == CH_W'(gi));
        end
    endgenerate

    assign bus.DACK        = bus.dack_sense_high ? dack_act : ~dack_act;
    assign bus.HRQ         = (state_reg != IDLE);
    assign bus.grant_valid = (state_reg == SERVE);
    assign bus.grant_ch    = (state_reg == SERVE) ? ch_q_reg : '0;
    assign bus.req_pending = eff_req_reg;

endmodule
